// File: rtl/tc_mode_sequencer_pkg.sv
// Shared types and tile geometry for the tensor-core mode sequencer.
// decode_tile() turns a run-time dtype/shape pair into per-tile counts.
package tc_mode_sequencer_pkg;

   localparam int K_DIM          = 16;
   localparam int RECV_BITS      = 256;
   localparam int RESET_CYC_DEF  = 2;
   localparam int CNT_W          = 8;
   localparam int FP_FORMAT_BITS = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      READ_C   = 3'd1,
      SYSTOLIC = 3'd2,
      FINISH   = 3'd3,
      RESET    = 3'd4
   } state_t;

   typedef enum logic [FP_FORMAT_BITS-1:0] {
      FP32 = 2'd0,
      FP16 = 2'd1,
      INT8 = 2'd2,
      INT4 = 2'd3
   } dtype_e;

   typedef enum logic [1:0] {
      M16N16        = 2'd0,
      M8N32         = 2'd1,
      M32N8         = 2'd2,
      SHAPE_ILLEGAL = 2'd3
   } shape_e;

   typedef struct packed {
      logic [CNT_W-1:0] m;
      logic [CNT_W-1:0] n;
      logic [CNT_W-1:0] c_beats;
      logic [CNT_W-1:0] k_steps;
      logic [CNT_W-1:0] drain;
   } tile_cfg_t;

   // An illegal shape yields m = n = 0; the other fields are then meaningless.
   function automatic tile_cfg_t decode_tile(dtype_e dtype, shape_e shape);
      tile_cfg_t cfg;
      int m;
      int n;
      int unit;
      int pack;
      case (shape)
         M16N16:  begin m = 16; n = 16; end
         M8N32:   begin m = 8;  n = 32; end
         M32N8:   begin m = 32; n = 8;  end
         default: begin m = 0;  n = 0;  end
      endcase
      unit = (dtype == INT4) ? 16 : 32;
      case (dtype)
         FP32:    pack = 1;
         FP16:    pack = 2;
         INT8:    pack = 4;
         default: pack = 8;
      endcase
      cfg.m       = CNT_W'(m);
      cfg.n       = CNT_W'(n);
      cfg.c_beats = CNT_W'((m * n * unit) / RECV_BITS);
      cfg.k_steps = CNT_W'(K_DIM / pack);
      cfg.drain   = CNT_W'(m + n - 2);
      return cfg;
   endfunction

endpackage

// File: rtl/tc_mode_sequencer_decode.sv
// Combinational command decoder: dtype/shape to tile geometry plus illegal flag.
module tc_tile_decode
   import tc_mode_sequencer_pkg::*;
(
   input  logic [FP_FORMAT_BITS-1:0] i_dtype,
   input  logic [1:0]                i_shape,
   output tile_cfg_t                 o_cfg,
   output logic                      o_illegal
);

   assign o_cfg     = decode_tile(dtype_e'(i_dtype), shape_e'(i_shape));
   assign o_illegal = (shape_e'(i_shape) == SHAPE_ILLEGAL);

endmodule

// File: rtl/tc_mode_sequencer.sv
// Per-tile PE-array control FSM: load C, feed/drain the systolic array,
// hand off the result, then clear the array before the next tile.
module tc_mode_sequencer
   import tc_mode_sequencer_pkg::*;
#(
   parameter int RESET_CYC = RESET_CYC_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [FP_FORMAT_BITS-1:0] cmd_dtype,
   input  logic [1:0]                cmd_shape,
   input  logic                      abort,
   input  logic                      c_valid,
   output logic                      c_ready,
   input  logic                      op_valid,
   output logic                      pe_shift_en,
   output logic [CNT_W-1:0]          feed_idx,
   output logic                      pe_clear,
   output logic                      done_valid,
   input  logic                      done_ready,
   output logic                      err,
   output logic [2:0]                state
);

   state_t           r_state;
   logic [CNT_W-1:0] r_beat_cnt;
   logic [CNT_W-1:0] r_step_cnt;
   logic [CNT_W-1:0] r_rst_cnt;
   logic [CNT_W-1:0] r_c_beats;
   logic [CNT_W-1:0] r_k_steps;
   logic [CNT_W-1:0] r_end_step;
   logic             r_err;

   tile_cfg_t        w_cfg;
   logic             w_illegal;
   logic             w_reject;
   logic             w_feed;
   logic             w_latch;
   logic             w_err_nxt;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_beat_nxt;
   logic [CNT_W-1:0] w_step_nxt;
   logic [CNT_W-1:0] w_rst_nxt;
   logic [CNT_W-1:0] w_beat_inc;
   logic [CNT_W-1:0] w_step_inc;

   tc_tile_decode u_decode (
      .i_dtype   (cmd_dtype),
      .i_shape   (cmd_shape),
      .o_cfg     (w_cfg),
      .o_illegal (w_illegal)
   );

   // A zero-sized tile can never complete, so it is rejected like an illegal shape.
   assign w_reject   = w_illegal || (w_cfg.m == '0) || (w_cfg.n == '0);
   assign w_feed     = (r_state == SYSTOLIC) && (r_step_cnt < r_k_steps);
   assign w_beat_inc = r_beat_cnt + CNT_W'(1);
   assign w_step_inc = r_step_cnt + CNT_W'(1);

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat_cnt;
      w_step_nxt  = r_step_cnt;
      w_rst_nxt   = r_rst_cnt;
      w_err_nxt   = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               if (w_reject) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_latch     = 1'b1;
                  w_beat_nxt  = '0;
                  w_state_nxt = READ_C;
               end
            end
         end
         READ_C: begin
            if (abort) begin
               w_rst_nxt   = '0;
               w_state_nxt = RESET;
            end else if (c_valid) begin
               w_beat_nxt = w_beat_inc;
               if (w_beat_inc == r_c_beats) begin
                  w_step_nxt  = '0;
                  w_state_nxt = SYSTOLIC;
               end
            end
         end
         SYSTOLIC: begin
            if (abort) begin
               w_rst_nxt   = '0;
               w_state_nxt = RESET;
            end else if (w_feed) begin
               if (op_valid) w_step_nxt = w_step_inc;
            end else begin
               w_step_nxt = w_step_inc;
               if (w_step_inc == r_end_step) w_state_nxt = FINISH;
            end
         end
         FINISH: begin
            if (abort || done_ready) begin
               w_rst_nxt   = '0;
               w_state_nxt = RESET;
            end
         end
         RESET: begin
            if (r_rst_cnt == CNT_W'(RESET_CYC - 1)) begin
               w_rst_nxt   = '0;
               w_state_nxt = IDLE;
            end else begin
               w_rst_nxt = r_rst_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_beat_cnt <= '0;
         r_step_cnt <= '0;
         r_rst_cnt  <= '0;
         r_c_beats  <= '0;
         r_k_steps  <= '0;
         r_end_step <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_beat_cnt <= w_beat_nxt;
         r_step_cnt <= w_step_nxt;
         r_rst_cnt  <= w_rst_nxt;
         r_err      <= w_err_nxt;
         if (w_latch) begin
            r_c_beats  <= w_cfg.c_beats;
            r_k_steps  <= w_cfg.k_steps;
            r_end_step <= w_cfg.k_steps + w_cfg.drain;
         end
      end
   end

   assign cmd_ready   = (r_state == IDLE);
   assign c_ready     = (r_state == READ_C);
   assign pe_shift_en = w_feed ? op_valid : (r_state == SYSTOLIC);
   assign feed_idx    = w_feed ? r_step_cnt : '0;
   assign pe_clear    = (r_state == RESET);
   assign done_valid  = (r_state == FINISH);
   assign err         = r_err;
   assign state       = r_state;

endmodule

// File: tb/tb_tc_mode_sequencer.sv
// Directed self-checking bench for tc_mode_sequencer.
module tb_tc_mode_sequencer;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_READ_C   = 3'd1;
   localparam logic [2:0] S_SYSTOLIC = 3'd2;
   localparam logic [2:0] S_FINISH   = 3'd3;
   localparam logic [2:0] S_RESET    = 3'd4;

   // FP16 m8n32 with op_valid dropped on SYSTOLIC cycles 3 and 5 (bit i = cycle i).
   localparam logic [9:0] FP16_SHIFT = 10'b1111010111;
   localparam int         FP16_IDX [10] = '{0, 1, 2, 3, 3, 4, 4, 5, 6, 7};

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_dtype;
   logic [1:0] cmd_shape;
   logic       abort;
   logic       c_valid;
   logic       c_ready;
   logic       op_valid;
   logic       pe_shift_en;
   logic [7:0] feed_idx;
   logic       pe_clear;
   logic       done_valid;
   logic       done_ready;
   logic       err;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   tc_mode_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_dtype   (cmd_dtype),
      .cmd_shape   (cmd_shape),
      .abort       (abort),
      .c_valid     (c_valid),
      .c_ready     (c_ready),
      .op_valid    (op_valid),
      .pe_shift_en (pe_shift_en),
      .feed_idx    (feed_idx),
      .pe_clear    (pe_clear),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .err         (err),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic step_cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic issue_cmd(input logic [1:0] dt, input logic [1:0] sh);
      cmd_dtype = dt;
      cmd_shape = sh;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
   endtask

   task automatic count_state(input logic [2:0] s, input int budget, output int n);
      n = 0;
      while (state === s && n < budget) begin
         n++;
         step_cyc();
      end
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (state !== S_IDLE && k < 200) begin
         k++;
         step_cyc();
      end
      n_checks++;
      if (state !== S_IDLE) begin
         n_fail++;
         $display("FAIL %s_wait_idle: state=%0d required %0d", name, state, S_IDLE);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step_cyc();
      step_cyc();
      n_checks++; if (state !== S_IDLE)   begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      n_checks++; if ({c_ready, pe_shift_en, pe_clear, done_valid, err} !== 5'b0)
         begin n_fail++; $display("FAIL reset_outputs: got %b want 00000", {c_ready, pe_shift_en, pe_clear, done_valid, err}); end
      n_checks++; if (feed_idx !== 8'd0)  begin n_fail++; $display("FAIL reset_feed_idx: got %0d want 0", feed_idx); end
      rst = 1'b0;
      step_cyc();
   endtask

   task automatic test_fp32_m16n16();
      int n;
      c_valid    = 1'b1;
      op_valid   = 1'b1;
      done_ready = 1'b0;
      issue_cmd(2'd0, 2'd0);
      n_checks++; if ({c_ready, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL fp32_readc_ready: got %b want 10", {c_ready, cmd_ready}); end
      count_state(S_READ_C, 100, n);
      n_checks++; if (n !== 32) begin n_fail++; $display("FAIL fp32_beats: got %0d want 32", n); end
      count_state(S_SYSTOLIC, 200, n);
      n_checks++; if (n !== 46) begin n_fail++; $display("FAIL fp32_systolic_cycles: got %0d want 46", n); end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({state, done_valid} !== {S_FINISH, 1'b1})
            begin n_fail++; $display("FAIL fp32_done_hold[%0d]: state=%0d done_valid=%b want 3/1", i, state, done_valid); end
         step_cyc();
      end
      done_ready = 1'b1;
      n_checks++; if (done_valid !== 1'b1) begin n_fail++; $display("FAIL fp32_done_handshake: got %b want 1", done_valid); end
      @(negedge clk);
      done_ready = 1'b0;
      #1;
      n = 0;
      while (state === S_RESET && n < 20) begin
         n_checks++; if (pe_clear !== 1'b1) begin n_fail++; $display("FAIL fp32_pe_clear: got %b want 1", pe_clear); end
         n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fp32_reset_cmd_ready: got %b want 0", cmd_ready); end
         n++;
         step_cyc();
      end
      n_checks++; if (n !== 2) begin n_fail++; $display("FAIL fp32_reset_cycles: got %0d want 2", n); end
      n_checks++; if ({state, cmd_ready, pe_clear} !== {S_IDLE, 1'b1, 1'b0})
         begin n_fail++; $display("FAIL fp32_back_idle: state=%0d cmd_ready=%b pe_clear=%b", state, cmd_ready, pe_clear); end
      c_valid  = 1'b0;
      op_valid = 1'b0;
   endtask

   task automatic test_int4_m32n8();
      int n;
      c_valid  = 1'b1;
      op_valid = 1'b1;
      issue_cmd(2'd3, 2'd2);
      count_state(S_READ_C, 100, n);
      n_checks++; if (n !== 16) begin n_fail++; $display("FAIL int4_beats: got %0d want 16", n); end
      n = 0;
      while (state === S_SYSTOLIC && n < 200) begin
         if (n < 2) begin
            n_checks++;
            if (feed_idx !== 8'(n)) begin n_fail++; $display("FAIL int4_feed_idx[%0d]: got %0d want %0d", n, feed_idx, n); end
         end
         n++;
         step_cyc();
      end
      n_checks++; if (n !== 40) begin n_fail++; $display("FAIL int4_systolic_cycles: got %0d want 40", n); end
      c_valid    = 1'b0;
      op_valid   = 1'b0;
      done_ready = 1'b1;
      step_cyc();
      done_ready = 1'b0;
      wait_idle("int4");
   endtask

   task automatic test_fp16_stall();
      int n;
      c_valid = 1'b1;
      issue_cmd(2'd1, 2'd1);
      count_state(S_READ_C, 100, n);
      n_checks++; if (n !== 32) begin n_fail++; $display("FAIL fp16_beats: got %0d want 32", n); end
      c_valid = 1'b0;
      n = 0;
      while (state === S_SYSTOLIC && n < 200) begin
         op_valid = (n < 10) && (n != 3) && (n != 5);
         #1;
         if (n < 10) begin
            n_checks++;
            if (pe_shift_en !== FP16_SHIFT[n]) begin n_fail++; $display("FAIL fp16_shift[%0d]: got %b want %b", n, pe_shift_en, FP16_SHIFT[n]); end
            n_checks++;
            if (feed_idx !== 8'(FP16_IDX[n])) begin n_fail++; $display("FAIL fp16_feed_idx[%0d]: got %0d want %0d", n, feed_idx, FP16_IDX[n]); end
         end else begin
            n_checks++;
            if (pe_shift_en !== 1'b1) begin n_fail++; $display("FAIL fp16_drain_shift[%0d]: got %b want 1", n, pe_shift_en); end
         end
         n++;
         step_cyc();
      end
      n_checks++; if (n !== 48) begin n_fail++; $display("FAIL fp16_systolic_cycles: got %0d want 48", n); end
      op_valid   = 1'b0;
      done_ready = 1'b1;
      step_cyc();
      done_ready = 1'b0;
      wait_idle("fp16");
   endtask

   task automatic test_illegal_shape();
      issue_cmd(2'd0, 2'd3);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b want 1", err); end
      n_checks++; if ({state, c_ready, cmd_ready} !== {S_IDLE, 1'b0, 1'b1})
         begin n_fail++; $display("FAIL illegal_stay_idle: state=%0d c_ready=%b cmd_ready=%b", state, c_ready, cmd_ready); end
      step_cyc();
      n_checks++; if ({err, state} !== {1'b0, S_IDLE}) begin n_fail++; $display("FAIL illegal_err_pulse: err=%b state=%0d want 0/0", err, state); end
      issue_cmd(2'd2, 2'd0);
      n_checks++; if ({state, err} !== {S_READ_C, 1'b0}) begin n_fail++; $display("FAIL illegal_then_legal: state=%0d err=%b want 1/0", state, err); end
      abort = 1'b1;
      step_cyc();
      abort = 1'b0;
      n_checks++; if (state !== S_RESET) begin n_fail++; $display("FAIL readc_abort: got %0d want %0d", state, S_RESET); end
      wait_idle("illegal");
   endtask

   task automatic test_abort_systolic();
      int n;
      logic seen_done;
      c_valid  = 1'b1;
      op_valid = 1'b1;
      issue_cmd(2'd0, 2'd0);
      count_state(S_READ_C, 100, n);
      repeat (20) step_cyc();
      n_checks++; if ({state, pe_shift_en} !== {S_SYSTOLIC, 1'b1})
         begin n_fail++; $display("FAIL abort_pre_state: state=%0d shift=%b want 2/1", state, pe_shift_en); end
      abort = 1'b1;
      step_cyc();
      abort = 1'b0;
      n_checks++; if (state !== S_RESET) begin n_fail++; $display("FAIL abort_next_state: got %0d want %0d", state, S_RESET); end
      n = 0;
      seen_done = 1'b0;
      while (state === S_RESET && n < 20) begin
         if (pe_clear !== 1'b1 || done_valid !== 1'b0) seen_done = 1'b1;
         n++;
         step_cyc();
      end
      n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_reset_outputs: bad pe_clear/done_valid seen=%b want 0", seen_done); end
      n_checks++; if (n !== 2) begin n_fail++; $display("FAIL abort_reset_cycles: got %0d want 2", n); end
      n_checks++; if ({state, done_valid} !== {S_IDLE, 1'b0}) begin n_fail++; $display("FAIL abort_back_idle: state=%0d done_valid=%b", state, done_valid); end
      c_valid  = 1'b0;
      op_valid = 1'b0;
   endtask

   task automatic test_rst_mid_readc();
      int n;
      c_valid = 1'b1;
      issue_cmd(2'd0, 2'd0);
      repeat (10) step_cyc();
      n_checks++; if (state !== S_READ_C) begin n_fail++; $display("FAIL rst_pre_state: got %0d want %0d", state, S_READ_C); end
      rst = 1'b1;
      #1;
      n_checks++; if ({state, pe_clear, c_ready} !== {S_IDLE, 1'b0, 1'b0})
         begin n_fail++; $display("FAIL rst_async: state=%0d pe_clear=%b c_ready=%b want 0/0/0", state, pe_clear, c_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      abort = 1'b1;
      issue_cmd(2'd0, 2'd0);
      abort = 1'b0;
      n_checks++; if (state !== S_READ_C) begin n_fail++; $display("FAIL idle_abort_ignored: got %0d want %0d", state, S_READ_C); end
      count_state(S_READ_C, 100, n);
      n_checks++; if (n !== 32) begin n_fail++; $display("FAIL rst_restart_beats: got %0d want 32", n); end
      c_valid = 1'b0;
      abort   = 1'b1;
      step_cyc();
      abort   = 1'b0;
      wait_idle("rst");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_dtype  = 2'd0;
      cmd_shape  = 2'd0;
      abort      = 1'b0;
      c_valid    = 1'b0;
      op_valid   = 1'b0;
      done_ready = 1'b0;
      test_reset();
      test_fp32_m16n16();
      test_int4_m32n8();
      test_fp16_stall();
      test_illegal_shape();
      test_abort_systolic();
      test_rst_mid_readc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
